sr16b_iter: RTL

Iterative 16-bit right shifter for the ALU datapath, the counterpart of the combinational left shifter. It shifts operand `a` right by `b[3:0]` positions, logical or arithmetic, one bit per clock, under a start/done handshake. Shifts are spread over multiple cycles so that no 16-way barrel mux is needed. The control unit stalls on `busy` and captures `r` on `done`.

---
 rtl/sr16_pkg.sv | 22 ++
 rtl/sr16_step.sv | 28 ++
 rtl/sr16b_iter.sv | 88 ++++++++
 3 files changed

// File: rtl/sr16_pkg.sv
// Shared definitions for the iterative 16-bit right shifter: widths, FSM state
// encoding and the per-step shift distances.
package sr16_pkg;

    localparam int SR_WIDTH = 16;
    localparam int SR_AMT_W = 4;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_DONE  = 2'd2
    } sr_state_t;

    localparam logic [SR_AMT_W-1:0] SR_STEP_ONE  = 4'd1;
    localparam logic [SR_AMT_W-1:0] SR_STEP_FOUR = 4'd4;

    // Bit shifted in at the top: sign bit for arithmetic shifts, zero otherwise.
    function automatic logic sr_fill_bit(input logic arith, input logic [SR_WIDTH-1:0] data);
        return arith & data[SR_WIDTH-1];
    endfunction

endpackage

// File: rtl/sr16_step.sv
// Combinational single-step right shifter. With SR16_FASTPATH_EN defined it can
// also move four bits in one step when step4 is high.
import sr16_pkg::*;

module sr16_step (
    input  logic [SR_WIDTH-1:0] data,
    input  logic                fill,
    input  logic                step4,
    output logic [SR_WIDTH-1:0] result
);

`ifdef SR16_FASTPATH_EN
    always_comb begin
        result = {fill, data[SR_WIDTH-1:1]};
        if (step4) begin
            result = {{4{fill}}, data[SR_WIDTH-1:4]};
        end
    end
`else
    logic unused_step4;
    assign unused_step4 = step4;

    always_comb begin
        result = {fill, data[SR_WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/sr16b_iter.sv
// Iterative 16-bit logical/arithmetic right shifter, one bit (or four bits with
// SR16_FASTPATH_EN defined) per clock, under a start/busy/done handshake.
import sr16_pkg::*;

module sr16b_iter #(
    parameter int WIDTH = SR_WIDTH,
    parameter int AMT_W = SR_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    // Handshake: start is accepted only on an edge where busy=0 (state IDLE);
    // busy then stays high until done drops, done pulses one cycle with r valid,
    // and r holds until the next accepted start. start is never queued.

    sr_state_t        state;
    logic [AMT_W-1:0] count;
    logic             fill;
    logic             step4;
    logic [AMT_W-1:0] count_dec;
    logic [AMT_W-1:0] count_next;
    logic [WIDTH-1:0] step_out;

    logic [WIDTH-AMT_W-1:0] unused_b_hi;
    assign unused_b_hi = b[WIDTH-1:AMT_W];

`ifdef SR16_FASTPATH_EN
    assign step4 = (count >= SR_STEP_FOUR);
`else
    assign step4 = 1'b0;
`endif

    assign count_dec  = step4 ? SR_STEP_FOUR : SR_STEP_ONE;
    assign count_next = count - count_dec;

    sr16_step u_step (
        .data   (r),
        .fill   (fill),
        .step4  (step4),
        .result (step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SR_IDLE;
            r     <= '0;
            count <= '0;
            fill  <= 1'b0;
        end else begin
            case (state)
                SR_IDLE: begin
                    if (start) begin
                        r     <= a;
                        count <= b[AMT_W-1:0];
                        fill  <= sr_fill_bit(arith, a);
                        state <= (b[AMT_W-1:0] != '0) ? SR_SHIFT : SR_DONE;
                    end
                end
                SR_SHIFT: begin
                    r     <= step_out;
                    count <= count_next;
                    // Leave as soon as the last pending bit has been shifted out.
                    if (count_next == '0) begin
                        state <= SR_DONE;
                    end
                end
                SR_DONE: begin
                    state <= SR_IDLE;
                end
                default: begin
                    state <= SR_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != SR_IDLE);
    assign done = (state == SR_DONE);

endmodule
